mux_rr_sel_stage: RTL
=====================

// Module: mux_rr_sel_stage
// PURPOSE
//   Upstream select/feed stage for the 2:1 data mux. Two valid/ready input channels (I0, I1) compete
//   for one registered output; a round-robin pointer chooses the winner each cycle and drives sel.
//   Output is a single registered slot with valid/ready backpressure; 1-cycle latency, 1 word/cycle.
// PARAMETERS
//   WIDTH     8   data width of I0, I1 and out
// PORTS
//   clk         in   1      rising-edge clock, single clock domain
//   rst         in   1      asynchronous, active-high reset
//   i0_valid    in   1      channel 0 has a word
//   i0_data     in   WIDTH  channel 0 word
//   i0_ready    out  1      channel 0 word accepted this cycle (combinational)
//   i1_valid    in   1      channel 1 has a word
//   i1_data     in   WIDTH  channel 1 word
//   i1_ready    out  1      channel 1 word accepted this cycle (combinational)
//   sel         out  1      registered source of out_data: 0=I0, 1=I1
//   out_valid   out  1      out_data holds an undelivered word
//   out_data    out  WIDTH  registered winning word
//   out_ready   in   1      downstream accepts out_data this cycle
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, out_data=0, sel=0, pointer=PREF0; i0_ready=i1_ready=0 while rst.
//   load_en = !out_valid | out_ready   (slot empty or being drained this cycle).
//   Pointer FSM, 2 states: PREF0 (I0 wins ties), PREF1 (I1 wins ties).
//     grant I0 -> next state PREF1; grant I1 -> next PREF0; no grant -> hold state.
//     State advances only on an actual transfer (load_en & granted valid).
//   Grant (combinational): only i0_valid -> I0; only i1_valid -> I1; both -> per pointer; none -> none.
//   iX_ready = load_en & grant==X & !rst. Never both high. Ready never asserted to a non-valid channel.
//   On clock edge with load_en:
//     grant exists -> out_data<=winner data, sel<=winner index, out_valid<=1.
//     no grant     -> out_valid<=0; out_data and sel hold last values.
//   Without load_en (out_valid & !out_ready): out_data, sel, out_valid, pointer all hold; both readies 0.
//   Transfer on output = out_valid & out_ready; simultaneous drain+refill same cycle gives back-to-back
//     words with no bubble.
//   Inputs must hold valid/data stable until ready; block drops nothing and duplicates nothing.
//   Starvation bound: a continuously valid channel is granted within 2 output transfers.
//   rst mid-transfer: held word is discarded, out_valid drops asynchronously, pointer returns to PREF0;
//     first grant after release follows PREF0 rule.
//   No arithmetic; data passes bit-exact, WIDTH bits, no sign or width change.
// TESTING
//   1 Reset: rst=1 with i0_valid=i1_valid=1 -> out_valid=0, sel=0, out_data=0, both ready=0.
//   2 Single channel: i0_valid=1 i0_data=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, sel=0;
//     repeat with I1 data 8'h3C -> out_data=3C, sel=1.
//   3 Round-robin: both valid continuously, I0=8'h11, I1=8'h22, out_ready=1 -> out_data sequence
//     11,22,11,22..., sel 0,1,0,1, one word per cycle, i0_ready/i1_ready alternate, never both high.
//   4 Backpressure: out_ready=0 for 3 cycles with word 8'h11 held -> out_data/sel/out_valid stable,
//     both readies 0, pointer unchanged; out_ready=1 -> 11 drained, next word 22 appears next cycle.
//   5 Reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid=0 immediately;
//     after release with both valid -> first output is I0 data (PREF0).
//   6 Scoreboard: 200 cycles random valid/out_ready -> every input word appears once, in per-channel
//     order, sel matches source; no channel waits more than 2 transfers while valid.

Source files
------------

// File: rtl/mux_rr_sel_stage.sv
// Round-robin select stage: two valid/ready channels compete for one registered output slot.
// The winner's word and index (sel) are captured together so downstream sees a consistent pair.
module mux_rr_sel_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } ptr_t;

  ptr_t state;
  ptr_t state_next;
  logic load_en;
  logic grant_any;
  logic grant_idx;

  // The slot can take a new word when it is empty or being drained in the same cycle.
  assign load_en = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PREF0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    grant_any  = i0_valid || i1_valid;
    grant_idx  = 1'b0;
    state_next = state;
    if (i1_valid && (!i0_valid || state == PREF1)) begin
      grant_idx = 1'b1;
    end
    // The pointer only moves past a channel once that channel's word has actually transferred.
    if (load_en && grant_any) begin
      state_next = grant_idx ? PREF0 : PREF1;
    end
  end

  assign i0_ready = load_en && grant_any && !grant_idx && !rst;
  assign i1_ready = load_en && grant_any &&  grant_idx && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 1'b0;
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_idx ? i1_data : i0_data;
        sel       <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
